// File: rtl/debounce_pulse.sv
// Switch debouncer: two-flop synchronizer feeding a four-state stability FSM
// that drives a registered level Q plus one-cycle RISE/FALL edge pulses.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_IN,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_q;
  logic             rise_q;
  logic             fall_q;

  // q_q is updated only on the CHK_HI->HIGH and CHK_LO->LOW transitions, so it
  // always equals "state is HIGH or CHK_LO" without a separate decode stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q   <= SW_IN;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s2_q) begin
            state_q <= CHK_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_HI: begin
          if (!s2_q) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2_q) begin
            state_q <= CHK_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_LO: begin
          if (s2_q) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboarded bench for debounce_pulse: a sample-history model predicts
// Q/RISE/FALL per edge; async reset behaviour is checked against fixed zeros.
module tb_debounce_pulse;

  localparam int SC = 4;

  logic CLK = 1'b0;
  logic RST;
  logic SW_IN;
  logic Q;
  logic RISE;
  logic FALL;

  typedef struct packed {
    logic q;
    logic r;
    logic f;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[$];
  bit   q_m;
  int   vectors = 0;
  int   miscompares = 0;

  debounce_pulse #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .SW_IN(SW_IN),
    .Q    (Q),
    .RISE (RISE),
    .FALL (FALL)
  );

  always #5 CLK = ~CLK;

  // Q toggles at edge n when the FSM's samples at edges n-SC+1..n, i.e. the
  // raw input present at edges n-2-SC+1..n-2, all differ from the current Q.
  task automatic apply(input bit sw);
    bit   all_diff;
    bit   smp;
    bit   q_new;
    int   n;
    int   m;
    exp_t e;
    SW_IN = sw;
    hist.push_back(sw);
    n = hist.size();
    all_diff = 1'b1;
    for (int k = 0; k < SC; k++) begin
      m = n - 3 - k;
      smp = (m >= 0) ? hist[m] : 1'b0;
      if (smp == q_m) all_diff = 1'b0;
    end
    q_new = all_diff ? ~q_m : q_m;
    e.q = q_new;
    e.r = q_new & ~q_m;
    e.f = ~q_new & q_m;
    q_m = q_new;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    hist.delete();
    q_m = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1'b1;
    SW_IN = 1'b0;
    #2;
    vectors++;
    if ({Q, RISE, FALL} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_noclk: got Q/RISE/FALL=%b%b%b want 000", Q, RISE, FALL);
    end
    @(posedge CLK);
    #5;
    RST = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) begin
      apply(1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({Q, RISE, FALL} !== {e.q, e.r, e.f}) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %b%b%b want %b%b%b", i + 1, Q, RISE, FALL, e.q, e.r, e.f);
      end
    end
  endtask

  task automatic test_edge(input bit lvl);
    exp_t e;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   hit_at = 0;
    for (int i = 0; i < 10; i++) begin
      apply(lvl);
      e = exp_q.pop_front();
      vectors++;
      if ({Q, RISE, FALL} !== {e.q, e.r, e.f}) begin
        miscompares++;
        $display("FAIL edge%0b cyc %0d: got %b%b%b want %b%b%b", lvl, i + 1, Q, RISE, FALL, e.q, e.r, e.f);
      end
      if (RISE) rise_cnt++;
      if (FALL) fall_cnt++;
      if ((lvl && RISE) || (!lvl && FALL)) hit_at = i + 1;
    end
    vectors++;
    if (hit_at != SC + 2 || rise_cnt != int'(lvl) || fall_cnt != int'(!lvl)) begin
      miscompares++;
      $display("FAIL edge%0b_pulse: got edge %0d rises %0d falls %0d want edge %0d one pulse",
               lvl, hit_at, rise_cnt, fall_cnt, SC + 2);
    end
  endtask

  task automatic test_bounce();
    bit   pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e;
    int   rise_cnt = 0;
    int   rise_at = 0;
    for (int i = 0; i < 16; i++) begin
      apply(i < 6 ? pat[i] : 1'b1);
      e = exp_q.pop_front();
      vectors++;
      if ({Q, RISE, FALL} !== {e.q, e.r, e.f}) begin
        miscompares++;
        $display("FAIL bounce cyc %0d: got %b%b%b want %b%b%b", i + 1, Q, RISE, FALL, e.q, e.r, e.f);
      end
      if (RISE) begin
        rise_cnt++;
        rise_at = i + 1;
      end
    end
    vectors++;
    if (rise_cnt != 1 || rise_at != 6 + SC + 1) begin
      miscompares++;
      $display("FAIL bounce_rise: got %0d rises at edge %0d want 1 at edge %0d", rise_cnt, rise_at, 6 + SC + 1);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   rise_at;
    SW_IN = 1'b1;
    for (int phase = 0; phase < 3; phase++) begin
      #4;
      RST = 1'b1;
      #1;
      vectors++;
      if ({Q, RISE, FALL} !== 3'b000) begin
        miscompares++;
        $display("FAIL rstmid%0d_async: got %b%b%b want 000", phase, Q, RISE, FALL);
      end
      @(posedge CLK);
      #1;
      vectors++;
      if ({Q, RISE, FALL} !== 3'b000) begin
        miscompares++;
        $display("FAIL rstmid%0d_hold: got %b%b%b want 000", phase, Q, RISE, FALL);
      end
      #4;
      RST = 1'b0;
      model_clear();
      if (phase == 2) break;
      rise_at = 0;
      for (int i = 0; i < ((phase == 0) ? 3 : 9); i++) begin
        apply(1'b1);
        e = exp_q.pop_front();
        vectors++;
        if ({Q, RISE, FALL} !== {e.q, e.r, e.f}) begin
          miscompares++;
          $display("FAIL rstmid%0d cyc %0d: got %b%b%b want %b%b%b", phase, i + 1, Q, RISE, FALL, e.q, e.r, e.f);
        end
        if (RISE) rise_at = i + 1;
      end
      if (phase == 1) begin
        vectors++;
        if (rise_at != SC + 2) begin
          miscompares++;
          $display("FAIL rstmid_rise: got edge %0d want %0d", rise_at, SC + 2);
        end
      end
    end
    rise_at = 0;
    for (int i = 0; i < 9; i++) begin
      apply(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if ({Q, RISE, FALL} !== {e.q, e.r, e.f}) begin
        miscompares++;
        $display("FAIL rstmid_after cyc %0d: got %b%b%b want %b%b%b", i + 1, Q, RISE, FALL, e.q, e.r, e.f);
      end
      if (RISE) rise_at = i + 1;
    end
    vectors++;
    if (rise_at != SC + 2) begin
      miscompares++;
      $display("FAIL rstmid_after_rise: got edge %0d want %0d", rise_at, SC + 2);
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    int   pulses = 0;
    logic q0;
    q0 = Q;
    for (int i = 0; i < 50; i++) begin
      apply(i[0]);
      e = exp_q.pop_front();
      vectors++;
      if ({Q, RISE, FALL} !== {e.q, e.r, e.f} || Q !== q0) begin
        miscompares++;
        $display("FAIL toggle cyc %0d: got %b%b%b want %b%b%b", i + 1, Q, RISE, FALL, e.q, e.r, e.f);
      end
      vectors++;
      if (dut.cnt_q > 4'(SC - 1)) begin
        miscompares++;
        $display("FAIL toggle_cnt cyc %0d: got cnt %0d want <= %0d", i + 1, dut.cnt_q, SC - 1);
      end
      if (RISE || FALL) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL toggle_pulses: got %0d want 0", pulses);
    end
  endtask

  initial begin
    RST = 1'b1;
    SW_IN = 1'b0;
    q_m = 1'b0;
    test_reset();
    test_edge(1'b1);
    test_edge(1'b0);
    test_bounce();
    test_reset_mid();
    test_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: number of consecutive synchronized samples needed to accept a new input level (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 4: stability counter width; the integrator guarantees 2^CNT_W > STABLE_CYCLES.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port SW_IN  input  1  raw, asynchronous, bouncing switch/button level.
REQ-006 The block SHALL have port Q  output  1  debounced level, registered.
REQ-007 The block SHALL have port RISE  output  1  one-cycle pulse when Q goes 0->1, registered.
REQ-008 The block SHALL have port FALL  output  1  one-cycle pulse when Q goes 1->0, registered.
REQ-009 The block SHALL use one clock, CLK, with reset RST asynchronous and active-high.

Function
REQ-010 SW_IN SHALL pass through a two-flop synchronizer (S1 then S2) before any other logic; only S2 feeds the FSM.
REQ-011 The FSM SHALL have exactly four states: LOW, CHK_HI, HIGH, CHK_LO.
REQ-012 In LOW: S2=1 -> CHK_HI with CNT=1; otherwise stay, CNT=0.
REQ-013 In CHK_HI: S2=0 -> LOW with CNT=0; S2=1 and CNT=STABLE_CYCLES-1 -> HIGH with CNT=0; else CNT+1.
REQ-014 In HIGH: S2=0 -> CHK_LO with CNT=1; otherwise stay, CNT=0.
REQ-015 In CHK_LO: S2=1 -> HIGH with CNT=0; S2=0 and CNT=STABLE_CYCLES-1 -> LOW with CNT=0; else CNT+1.
REQ-016 Q SHALL be 1 exactly when the state is HIGH or CHK_LO, registered with the state.
REQ-017 RISE SHALL be 1 for exactly the one cycle after the CHK_HI->HIGH transition edge; FALL likewise for CHK_LO->LOW; RISE and FALL SHALL never be 1 together.
REQ-018 Latency: a clean SW_IN change set up before rising edge 1 SHALL appear on Q, with the matching pulse, after rising edge STABLE_CYCLES+2 (2 synchronizer edges + STABLE_CYCLES FSM edges).
REQ-019 Any S2 reversal during CHK_HI/CHK_LO SHALL abort the check, leave Q unchanged and produce no pulse; bounces shorter than STABLE_CYCLES cycles SHALL never reach Q.
REQ-020 CNT SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-021 All outputs SHALL change only on rising CLK edges (or on reset), so they are stable before a downstream stage sampling on the falling CLK edge.

Reset
REQ-022 RST=1 SHALL immediately, without a clock, force S1=0, S2=0, state=LOW, CNT=0, Q=0, RISE=0, FALL=0.
REQ-023 Reset asserted mid-check or while HIGH SHALL discard all progress; no RISE/FALL pulse SHALL be emitted due to reset.
REQ-024 After RST falls, operation SHALL restart from LOW; with SW_IN held 1 through reset, Q SHALL rise after rising edge STABLE_CYCLES+2 following release, with a RISE pulse.

Verification (STABLE_CYCLES=4)
REQ-025 RST pulse, SW_IN=0 for 20 cycles -> Q=0, RISE=0, FALL=0 throughout.
REQ-026 SW_IN 0->1 before edge 1, held -> Q=1 after edge 6; RISE=1 for that one cycle only; FALL stays 0.
REQ-027 From Q=1, SW_IN 1->0 held -> Q=0 after edge 6 from change; FALL one-cycle pulse; RISE stays 0.
REQ-028 From Q=0, SW_IN bounces 1,0,1,1,0,1 (one cycle each) then held 1 -> Q stays 0 during bounces; exactly one RISE, 6 edges after the final 0->1.
REQ-029 SW_IN=1 held; assert RST asynchronously (mid-clock) at cycle 4, then at cycle 10 after Q=1 -> Q, RISE, FALL go 0 at once, no pulse; after each release Q=1 at edge 6.
REQ-030 SW_IN toggled every cycle for 50 cycles -> Q constant, zero RISE/FALL pulses; CNT never exceeds 3 (assertion).
